commit_trace_tx: RTL and testbench

Synthesizable trace transmitter for the pipelined RV32 core. It samples the core's `pc_out`/`instr_out` every cycle and records each PC change as a two-beat record. It also emits a one-shot marker record when the PC stays stuck for a programmable number of cycles. Records are buffered in a small FIFO and streamed out over a valid/ready word interface to an off-core trace sink such as a debug UART or a bench monitor.

---
 rtl/commit_trace_tx.sv | 181 ++++++++++++++++++
 tb/tb_commit_trace_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: records PC changes (and optional stuck-PC markers) into a FIFO
// and streams them as two-beat records. Stuck detection is built when COMMIT_TRACE_STUCK_EN is defined.
module commit_trace_tx #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STUCK_THRESH = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        trace_en,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic [1:0]  tx_kind,
  output logic        tx_last,
  output logic        stuck,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DepthCnt = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CntOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  typedef struct packed {
    logic        stk;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  // Sample register
  logic        first_q;
  logic [31:0] last_pc_q;
  logic        pc_chg, pc_same;

  assign pc_chg  = trace_en && (first_q || (pc_in != last_pc_q));
  assign pc_same = trace_en && !first_q && (pc_in == last_pc_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q   <= 1'b1;
      last_pc_q <= '0;
    end else if (trace_en) begin
      first_q   <= 1'b0;
      last_pc_q <= pc_in;
    end
  end

  logic   stk_push;
  entry_t push_entry;

`ifdef COMMIT_TRACE_STUCK_EN
  localparam int unsigned RW = $clog2(STUCK_THRESH + 1);
  localparam logic [RW-1:0] RunMax = STUCK_THRESH[RW-1:0];
  localparam logic [RW-1:0] RunOne = RW'(1);

  logic [RW-1:0] run_q, run_d;
  logic          stuck_q, stuck_d;
  logic [31:0]   cycle_cnt_q;

  // The marker fires only on the transition into RunMax; saturation keeps it one-shot.
  always_comb begin
    run_d    = run_q;
    stuck_d  = stuck_q;
    stk_push = 1'b0;
    if (pc_chg) begin
      run_d   = '0;
      stuck_d = 1'b0;
    end else if (pc_same && (run_q != RunMax)) begin
      run_d = run_q + RunOne;
      if (run_d == RunMax) begin
        stk_push = 1'b1;
        stuck_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= '0;
      stuck_q     <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      run_q       <= run_d;
      stuck_q     <= stuck_d;
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign stuck      = stuck_q;
  assign push_entry = '{stk: stk_push, pc: pc_in, data: (stk_push ? cycle_cnt_q : instr_in)};
`else
  assign stk_push   = 1'b0;
  assign stuck      = 1'b0;
  assign push_entry = '{stk: 1'b0, pc: pc_in, data: instr_in};
`endif

  // Record FIFO
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   drop_cnt_q;
  logic          push, push_ok, pop;
  entry_t        rd_entry;
  state_e        state_q;

  assign push     = pc_chg || stk_push;
  assign pop      = (count_q != '0) && ((state_q == StIdle) || ((state_q == StBeat1) && tx_ready));
  assign push_ok  = push && ((count_q < DepthCnt) || pop);
  assign rd_entry = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push_ok && !pop)      count_q <= count_q + CntOne;
      else if (!push_ok && pop) count_q <= count_q - CntOne;
      if (push && !push_ok && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;

  // Serializer with registered stream outputs
  logic        tx_valid_q, tx_last_q, hold_stk_q;
  logic [31:0] tx_data_q, hold_data_q;
  logic [1:0]  tx_kind_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_kind_q   <= 2'd0;
      tx_last_q   <= 1'b0;
      hold_data_q <= '0;
      hold_stk_q  <= 1'b0;
    end else if (pop) begin
      state_q     <= StBeat0;
      tx_valid_q  <= 1'b1;
      tx_data_q   <= rd_entry.pc;
      tx_kind_q   <= rd_entry.stk ? 2'd2 : 2'd0;
      tx_last_q   <= 1'b0;
      hold_data_q <= rd_entry.data;
      hold_stk_q  <= rd_entry.stk;
    end else if (tx_ready) begin
      case (state_q)
        StBeat0: begin
          state_q   <= StBeat1;
          tx_data_q <= hold_data_q;
          tx_kind_q <= hold_stk_q ? 2'd3 : 2'd1;
          tx_last_q <= 1'b1;
        end
        StBeat1: begin
          state_q    <= StIdle;
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_kind  = tx_kind_q;
  assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Scoreboard bench for commit_trace_tx: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted beat and checks stream stability during stalls.
module tb_commit_trace_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        trace_en = 1'b0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic [1:0]  tx_kind;
  logic        tx_last;
  logic        stuck;
  logic [15:0] drop_cnt;

`ifdef COMMIT_TRACE_STUCK_EN
  localparam logic [31:0] StkExp = 32'd1;
`else
  localparam logic [31:0] StkExp = 32'd0;
`endif

  commit_trace_tx #(.FIFO_DEPTH(8), .STUCK_THRESH(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .trace_en (trace_en),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_kind  (tx_kind),
    .tx_last  (tx_last),
    .stuck    (stuck),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  kind;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_rec = 0;
  int    n_beats = 0;
  int    skipped = 0;
  bit    tolerant = 1'b0;
  bit    stall = 1'b0;
  beat_t prev;

`ifdef COMMIT_TRACE_STUCK_EN
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cyc <= '0;
    else          tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chg(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back('{data: pc, kind: 2'd0, last: 1'b0});
    exp_q.push_back('{data: instr, kind: 2'd1, last: 1'b1});
  endtask

  // In tolerant mode, records the DUT dropped are skipped until the next matching PC beat.
  task automatic accept();
    beat_t e;
    if (tolerant && (tx_kind == 2'd0)) begin
      while ((exp_q.size() >= 2) && (exp_q[0].kind == 2'd0) && (exp_q[0].data != tx_data)) begin
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        skipped++;
      end
    end
    check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("beat_data", tx_data, e.data);
      check("beat_kind", 32'(tx_kind), 32'(e.kind));
      check("beat_last", 32'(tx_last), 32'(e.last));
    end
    n_beats++;
    if (tx_last) n_rec++;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", tx_data, prev.data);
        check("stall_kind", 32'(tx_kind), 32'(prev.kind));
        check("stall_last", 32'(tx_last), 32'(prev.last));
      end
      if (tx_valid && tx_ready) accept();
      stall = tx_valid && !tx_ready;
      prev  = '{data: tx_data, kind: tx_kind, last: tx_last};
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    repeat (2) cyc();
    while (tx_valid && (n < 500)) begin
      cyc();
      n++;
    end
    check({nm, "_idle"}, 32'(tx_valid), 32'd0);
    if (!tolerant) check({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, drop0, rec0;

    // Reset values
    repeat (3) cyc();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", tx_data, 32'd0);
    check("rst_kind", 32'(tx_kind), 32'd0);
    check("rst_last", 32'(tx_last), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Three changing PCs, check first-beat latency
    tx_ready = 1'b1;
    trace_en = 1'b1;
    pc_in = 32'h0;  instr_in = 32'h0000_0013;
    cyc();
    push_chg(32'h0, 32'h0000_0013);
    check("lat_k_valid", 32'(tx_valid), 32'd0);
    pc_in = 32'h4;  instr_in = 32'h0010_0093;
    cyc();
    push_chg(32'h4, 32'h0010_0093);
    check("lat_k1_valid", 32'(tx_valid), 32'd1);
    check("lat_k1_data", tx_data, 32'h0);
    pc_in = 32'h8;  instr_in = 32'h0020_0113;
    cyc();
    push_chg(32'h8, 32'h0020_0113);
    trace_en = 1'b0;
    drain("t1");
    check("t1_rec", 32'(n_rec), 32'd3);

    // PC held for 20 samples, then a change
    trace_en = 1'b1;
    pc_in = 32'h100;  instr_in = 32'h0000_006F;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 0) push_chg(32'h100, 32'h0000_006F);
`ifdef COMMIT_TRACE_STUCK_EN
      if (i == 5) begin
        exp_q.push_back('{data: 32'h100, kind: 2'd2, last: 1'b0});
        exp_q.push_back('{data: tb_cyc - 32'd1, kind: 2'd3, last: 1'b1});
      end
`endif
      if (i == 4)  check("stuck_5th", 32'(stuck), 32'd0);
      if (i == 5)  check("stuck_6th", 32'(stuck), StkExp);
      if (i == 19) check("stuck_20th", 32'(stuck), StkExp);
    end
    pc_in = 32'h104;  instr_in = 32'h0041_0113;
    cyc();
    push_chg(32'h104, 32'h0041_0113);
    check("stuck_cleared", 32'(stuck), 32'd0);
    trace_en = 1'b0;
    drain("t2");

    // Stalled sink, 12 changes: 1 in serializer, 8 buffered, 3 dropped
    tx_ready = 1'b0;
    trace_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pc_in = 32'h200 + 32'(4 * i);
      instr_in = 32'hA000 + 32'(i);
      cyc();
      if (i < 9) push_chg(32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
    end
    trace_en = 1'b0;
    check("t3_drop", 32'(drop_cnt), 32'd3);
    repeat (3) cyc();
    check("t3_hold_valid", 32'(tx_valid), 32'd1);
    check("t3_hold_data", tx_data, 32'h200);
    b0 = n_beats;
    tx_ready = 1'b1;
    drain("t3");
    check("t3_beats", 32'(n_beats - b0), 32'd18);

    // Random backpressure over 1000 changing PCs
    tolerant = 1'b1;
    drop0 = int'(drop_cnt);
    rec0 = n_rec;
    skipped = 0;
    trace_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      pc_in = 32'h1000 + 32'(4 * i);
      instr_in = 32'(i) ^ 32'h5A5A_0000;
      tx_ready = ($urandom_range(0, 3) != 0);
      cyc();
      push_chg(32'h1000 + 32'(4 * i), 32'(i) ^ 32'h5A5A_0000);
    end
    trace_en = 1'b0;
    tx_ready = 1'b1;
    drain("t4");
    skipped += exp_q.size() / 2;
    exp_q.delete();
    tolerant = 1'b0;
    check("t4_skip_vs_drop", 32'(skipped), 32'(int'(drop_cnt) - drop0));
    check("t4_total", 32'((n_rec - rec0) + (int'(drop_cnt) - drop0)), 32'd1000);

    // Reset while in BEAT1, then the same PC must be recorded again
    tx_ready = 1'b0;
    trace_en = 1'b1;
    pc_in = 32'h300;  instr_in = 32'h0000_0073;
    cyc();
    push_chg(32'h300, 32'h0000_0073);
    trace_en = 1'b0;
    cyc();
    check("t5_beat0_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("t5_beat1_last", 32'(tx_last), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_last", 32'(tx_last), 32'd0);
    exp_q.delete();
    cyc();
    reset_n = 1'b1;
    check("t5_drop_clr", 32'(drop_cnt), 32'd0);
    check("t5_stuck_clr", 32'(stuck), 32'd0);
    tx_ready = 1'b1;
    trace_en = 1'b1;
    cyc();
    push_chg(32'h300, 32'h0000_0073);
    trace_en = 1'b0;
    b0 = n_beats;
    drain("t5");
    check("t5_beats", 32'(n_beats - b0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
